// File: rtl/sdram_memtest.sv
// sdram_memtest: self-test bus initiator for the SDRAM transaction interface.
// A write pass fills a word-address range with a generated pattern, a read
// pass reads it back and compares. The first error stops the test and
// latches diagnostics (code, address, expected and received data).
module sdram_memtest #(
   parameter int TIMEOUT = 1023,  // max stb-high cycles without ack (10-bit counter)
   parameter int GAP     = 1      // stb-low idle cycles between transactions, 1..3
) (
   input  logic        clk_p,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [15:0] seed,
   input  logic [20:0] start_adr,
   input  logic [20:0] end_adr,
   input  logic        sdram_ready,
   output logic        sdram_stb,
   output logic        sdram_we,
   output logic [1:0]  sdram_sel,
   output logic [20:0] sdram_adr,
   output logic [15:0] sdram_out,
   input  logic [15:0] sdram_dat,
   input  logic        sdram_ack,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [20:0] err_adr,
   output logic [15:0] err_exp,
   output logic [15:0] err_got
);

   // Last value of the timeout counter before the strobe is abandoned:
   // stb stays high exactly TIMEOUT cycles.
   localparam logic [9:0] TO_LAST     = 10'(TIMEOUT - 1);
   // WR_GAP lasts GAP cycles; RD_GAP lasts GAP-1 because RD_CHK is itself
   // the first idle cycle after a read (RD_GAP is skipped when GAP==1).
   localparam logic [1:0] WR_GAP_LAST = 2'(GAP - 1);
   localparam logic [1:0] RD_GAP_LAST = 2'(GAP - 2);

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISMATCH = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_RANGE    = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_WR_REQ,
      S_WR_GAP,
      S_RD_REQ,
      S_RD_CHK,
      S_RD_GAP,
      S_DONE,
      S_FAIL
   } state_e;

   // Test pattern for one word address (bits 16:1 of the byte address).
   function automatic logic [15:0] pattern(input logic [1:0]  m,
                                           input logic [15:0] s,
                                           input logic [15:0] w);
      logic [15:0] p;
      unique case (m)
         2'b00:   p = w ^ s;
         2'b01:   p = ~w ^ s;
         2'b10:   p = s;
         default: p = {w[7:0], w[15:8]} ^ s;
      endcase
      return p;
   endfunction

   state_e      state_q, state_d;
   logic [20:0] cur_q, cur_d;
   logic [20:0] start_q, start_d;
   logic [20:0] end_q, end_d;
   logic [1:0]  mode_q, mode_d;
   logic [15:0] seed_q, seed_d;
   logic        stb_q, stb_d;
   logic        we_q, we_d;
   logic [20:0] adr_q, adr_d;
   logic [15:0] out_q, out_d;
   logic [15:0] rdata_q, rdata_d;
   logic [9:0]  to_cnt_q, to_cnt_d;
   logic [1:0]  gap_q, gap_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [20:0] err_adr_q, err_adr_d;
   logic [15:0] err_exp_q, err_exp_d;
   logic [15:0] err_got_q, err_got_d;

   logic [15:0] pat;
   logic        rd_next;

   assign pat = pattern(mode_q, seed_q, cur_q[15:0]);

   // Next-state, bus handshake and diagnostic capture.
   always_comb begin
      // NOTE: every signal assigned here gets a default first; a path that
      // skips an assignment would otherwise infer a latch.
      state_d    = state_q;
      cur_d      = cur_q;
      start_d    = start_q;
      end_d      = end_q;
      mode_d     = mode_q;
      seed_d     = seed_q;
      stb_d      = stb_q;
      we_d       = we_q;
      adr_d      = adr_q;
      out_d      = out_q;
      rdata_d    = rdata_q;
      to_cnt_d   = to_cnt_q;
      gap_d      = gap_q;
      err_code_d = err_code_q;
      err_adr_d  = err_adr_q;
      err_exp_d  = err_exp_q;
      err_got_d  = err_got_q;
      rd_next    = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               start_d    = start_adr;
               end_d      = end_adr;
               mode_d     = mode;
               seed_d     = seed;
               err_code_d = ERR_NONE;
               err_adr_d  = '0;
               err_exp_d  = '0;
               err_got_d  = '0;
               if (end_adr < start_adr) begin
                  err_code_d = ERR_RANGE;
                  err_adr_d  = start_adr;
                  state_d    = S_FAIL;
               end else begin
                  cur_d   = start_adr;
                  state_d = S_WAIT_RDY;
               end
            end
         end

         S_WAIT_RDY: begin
            if (sdram_ready) state_d = S_WR_REQ;
         end

         S_WR_REQ, S_RD_REQ: begin
            if (!stb_q) begin
               // First cycle in the state: raise the strobe with a stable request.
               stb_d    = 1'b1;
               we_d     = (state_q == S_WR_REQ);
               adr_d    = cur_q;
               to_cnt_d = '0;
               if (state_q == S_WR_REQ) out_d = pat;
            end else if (sdram_ack) begin
               stb_d = 1'b0;
               we_d  = 1'b0;
               gap_d = '0;
               if (state_q == S_WR_REQ) begin
                  state_d = S_WR_GAP;
               end else begin
                  rdata_d = sdram_dat;
                  state_d = S_RD_CHK;
               end
            end else if (to_cnt_q == TO_LAST) begin
               stb_d      = 1'b0;
               we_d       = 1'b0;
               err_code_d = ERR_TIMEOUT;
               err_adr_d  = cur_q;
               err_exp_d  = pat;
               err_got_d  = '0;
               state_d    = S_FAIL;
            end else begin
               to_cnt_d = to_cnt_q + 10'd1;
            end
         end

         S_WR_GAP: begin
            if (gap_q == WR_GAP_LAST) begin
               if (cur_q == end_q) begin
                  cur_d   = start_q;
                  state_d = S_RD_REQ;
               end else begin
                  cur_d   = cur_q + 21'd1;
                  state_d = S_WR_REQ;
               end
            end else begin
               gap_d = gap_q + 2'd1;
            end
         end

         S_RD_CHK: begin
            if (rdata_q != pat) begin
               err_code_d = ERR_MISMATCH;
               err_adr_d  = cur_q;
               err_exp_d  = pat;
               err_got_d  = rdata_q;
               state_d    = S_FAIL;
            end else if (GAP == 1) begin
               rd_next = 1'b1;
            end else begin
               gap_d   = '0;
               state_d = S_RD_GAP;
            end
         end

         S_RD_GAP: begin
            if (gap_q == RD_GAP_LAST) rd_next = 1'b1;
            else                      gap_d   = gap_q + 2'd1;
         end

         default: state_d = S_IDLE;
      endcase

      // End of a read slot: finish on the last address, else move on.
      // The comparison precedes the increment, so 0x1FFFFF never wraps.
      if (rd_next) begin
         if (cur_q == end_q) begin
            state_d = S_DONE;
         end else begin
            cur_d   = cur_q + 21'd1;
            state_d = S_RD_REQ;
         end
      end
   end

   // State and datapath registers; reset drops the strobe immediately.
   always_ff @(posedge clk_p or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cur_q      <= '0;
         start_q    <= '0;
         end_q      <= '0;
         mode_q     <= '0;
         seed_q     <= '0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         out_q      <= '0;
         rdata_q    <= '0;
         to_cnt_q   <= '0;
         gap_q      <= '0;
         err_code_q <= ERR_NONE;
         err_adr_q  <= '0;
         err_exp_q  <= '0;
         err_got_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples
         // the pre-edge value of the others, independent of statement order.
         state_q    <= state_d;
         cur_q      <= cur_d;
         start_q    <= start_d;
         end_q      <= end_d;
         mode_q     <= mode_d;
         seed_q     <= seed_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         out_q      <= out_d;
         rdata_q    <= rdata_d;
         to_cnt_q   <= to_cnt_d;
         gap_q      <= gap_d;
         err_code_q <= err_code_d;
         err_adr_q  <= err_adr_d;
         err_exp_q  <= err_exp_d;
         err_got_q  <= err_got_d;
      end
   end

   assign sdram_stb = stb_q;
   assign sdram_we  = we_q;
   assign sdram_sel = 2'b11;
   assign sdram_adr = adr_q;
   assign sdram_out = out_q;

   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
   assign done     = (state_q == S_DONE);
   assign err      = (state_q == S_FAIL);
   assign err_code = err_code_q;
   assign err_adr  = err_adr_q;
   assign err_exp  = err_exp_q;
   assign err_got  = err_got_q;

endmodule
